pe_block_sched: RTL and testbench
=================================

# pe_block_sched

Tile scheduler that sequences one 8-row × 4-column PE_block across a job of N tiles. Per tile it:
- fetches one packed bias word and PE_W ifmap/weight words from on-chip buffers;
- pulses the PE start and streams operands;
- waits for PE valid, captures the 8 × 32-bit ofmap;
- serializes it row by row on a valid/ready output port.

It sits between the activation/weight/bias SRAMs and the PE_block in the accelerator datapath.

## Interface
Parameters:
- DATA_SIZE, 8, operand width
- PE_W, 4, ifmap/weight elements per tile (PE columns)
- PE_H, 8, PE rows (output channels)
- ACC_W, 32, bias/ofmap width
- ADDR_W, 10, buffer address width
- TILE_W, 8, tile-count width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job start pulse; honoured only in IDLE
- num_tiles  in  TILE_W  tile count, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle job-complete pulse
- ifm_rd_en / ifm_rd_addr  out  1 / ADDR_W  ifmap buffer read, data one cycle later
- ifm_rd_data  in  DATA_SIZE  ifmap word
- wgt_rd_en / wgt_rd_addr  out  1 / ADDR_W  weight read, one word = PE_H weights
- wgt_rd_data  in  PE_H*DATA_SIZE  row r at bits [r*DATA_SIZE +: DATA_SIZE]
- bias_rd_en / bias_rd_addr  out  1 / ADDR_W  bias read
- bias_rd_data  in  PE_H*ACC_W  packed biases, row r at [r*ACC_W +: ACC_W]
- pe_en  out  1  PE_block start pulse (i_en)
- pe_ifmap  out  DATA_SIZE  PE ifmap operand
- pe_weight  out  PE_H*DATA_SIZE  PE weight operands
- pe_bias  out  PE_H*ACC_W  PE biases
- pe_valid  in  1  PE result valid
- pe_ofmap  in  PE_H*ACC_W  PE results
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  ACC_W  one ofmap row
- out_row  out  $clog2(PE_H)  row index of out_data
- out_tile  out  TILE_W  tile index of out_data

## Operation
FSM states and transitions:
- IDLE:
  - start with num_tiles > 0 → BIAS, tile = 0.
  - start with num_tiles == 0 → DONE.
- BIAS: stall while pe_valid == 1. Otherwise bias_rd_en = 1 with bias_rd_addr = tile, then → FEED, k = 0.
- FEED, k = 0..PE_W (PE_W+1 cycles):
  - For k < PE_W: ifm_rd_en = wgt_rd_en = 1; both addresses = tile*PE_W + k.
  - At k = 0: pe_bias register loads bias_rd_data.
  - For k = 1..PE_W: pe_ifmap = ifm_rd_data and pe_weight = wgt_rd_data, passed combinationally.
  - pe_en = 1 only at k = 1.
  - After k = PE_W → WAIT.
- WAIT: on the first cycle with pe_valid = 1, capture pe_ofmap → DRAIN, row = 0.
- DRAIN: present captured row `row`. On out_valid && out_ready, row++. After row PE_H-1 is accepted:
  - tile+1 < num_tiles → BIAS, tile++.
  - otherwise → DONE.
- DONE: done = 1 for one cycle, busy = 0, → IDLE.

Rules:
- pe_bias is held stable from FEED k = 0 until the next tile's load.
- Address arithmetic is truncated to ADDR_W; job size must satisfy num_tiles*PE_W ≤ 2^ADDR_W.
- No read enable is asserted outside BIAS and FEED.
- start while busy is ignored; num_tiles is not re-sampled.

## Timing
- All outputs reset to 0; FSM resets to IDLE, counters to 0.
- rst mid-job aborts immediately: no done, no further reads, out_valid drops.
- Accepted start at cycle S → BIAS at S+1, assuming pe_valid = 0.
- With BIAS at cycle B:
  - FEED occupies B+1..B+1+PE_W.
  - pe_en is at B+2; operands k = 0..PE_W-1 are presented at B+2..B+1+PE_W.
- WAIT lasts until pe_valid, with PE latency L counted from pe_en.
- out_valid rises the cycle after capture.
- out_data, out_row and out_tile hold stable while out_valid && !out_ready.
- Drain takes PE_H cycles at out_ready = 1.
- The next tile's BIAS follows the cycle after the last row is accepted.
- done is asserted the cycle after the final handshake; busy falls in that same cycle.
- Job with num_tiles == 0: busy for one cycle, done at S+2.

## Structure
- Shared package pe_pkg holds:
  - DATA_SIZE, PE_W, PE_H, ACC_W
  - FSM state enum {IDLE, BIAS, FEED, WAIT, DRAIN, DONE}
- One natural sub-module, pe_ofmap_serializer, containing:
  - the PE_H × ACC_W capture register
  - the row counter and valid/ready output stage
  - a `last` indication back to the FSM

## Test plan
- num_tiles = 1, bias/weight/ifmap from the golden set, out_ready = 1 → 8 rows out_row 0..7 match golden, each pe_en a single cycle, done once.
- num_tiles = 3 → ifm/wgt addresses 0..11 in order, bias addresses 0,1,2, out_tile 0,0,…,2, one pe_en per tile.
- out_ready toggled 1-0-0-1 during DRAIN → out_data stable while stalled, no row lost or duplicated.
- pe_valid held high into the next BIAS → no bias_rd_en until pe_valid = 0.
- start with num_tiles = 0 → no read enables, done at S+2; start during busy → ignored.
- rst asserted during FEED of tile 1 → all outputs 0 immediately; a fresh start replays tile 0 correctly.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the PE_block tile scheduler.
package pe_pkg;

    localparam int DATA_SIZE = 8;
    localparam int PE_W      = 4;
    localparam int PE_H      = 8;
    localparam int ACC_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        FEED,
        WAIT,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/pe_ofmap_serializer.sv
// Captures one PE_H x ACC_W ofmap and emits it row by row on a valid/ready port.
module pe_ofmap_serializer #(
    parameter int PE_H  = pe_pkg::PE_H,
    parameter int ACC_W = pe_pkg::ACC_W,
    parameter int ROW_W = $clog2(PE_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [PE_H*ACC_W-1:0] ofmap,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ACC_W-1:0]      out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic                  last
);

    logic [ACC_W-1:0] cap [PE_H];
    logic [ROW_W-1:0] row;
    logic             valid;

    // Capture register, row pointer and output-valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PE_H; i++) cap[i] <= '0;
            row   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            for (int unsigned i = 0; i < PE_H; i++) cap[i] <= ofmap[i*ACC_W +: ACC_W];
            row   <= '0;
            valid <= 1'b1;
        end else if (valid && out_ready) begin
            if (row == ROW_W'(PE_H - 1)) begin
                row   <= '0;
                valid <= 1'b0;
            end else begin
                row <= row + ROW_W'(1);
            end
        end
    end

    assign out_valid = valid;
    assign out_data  = valid ? cap[row] : '0;
    assign out_row   = valid ? row : '0;
    assign last      = valid && out_ready && (row == ROW_W'(PE_H - 1));

endmodule

// File: rtl/pe_block_sched.sv
// Tile scheduler: fetches bias/ifmap/weights per tile, drives one PE_block,
// and drains each captured ofmap through pe_ofmap_serializer.
module pe_block_sched
    import pe_pkg::*;
#(
    parameter int DATA_SIZE = pe_pkg::DATA_SIZE,
    parameter int PE_W      = pe_pkg::PE_W,
    parameter int PE_H      = pe_pkg::PE_H,
    parameter int ACC_W     = pe_pkg::ACC_W,
    parameter int ADDR_W    = 10,
    parameter int TILE_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [TILE_W-1:0]         num_tiles,
    output logic                      busy,
    output logic                      done,
    output logic                      ifm_rd_en,
    output logic [ADDR_W-1:0]         ifm_rd_addr,
    input  logic [DATA_SIZE-1:0]      ifm_rd_data,
    output logic                      wgt_rd_en,
    output logic [ADDR_W-1:0]         wgt_rd_addr,
    input  logic [PE_H*DATA_SIZE-1:0] wgt_rd_data,
    output logic                      bias_rd_en,
    output logic [ADDR_W-1:0]         bias_rd_addr,
    input  logic [PE_H*ACC_W-1:0]     bias_rd_data,
    output logic                      pe_en,
    output logic [DATA_SIZE-1:0]      pe_ifmap,
    output logic [PE_H*DATA_SIZE-1:0] pe_weight,
    output logic [PE_H*ACC_W-1:0]     pe_bias,
    input  logic                      pe_valid,
    input  logic [PE_H*ACC_W-1:0]     pe_ofmap,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic [$clog2(PE_H)-1:0]   out_row,
    output logic [TILE_W-1:0]         out_tile
);

    localparam int K_W   = $clog2(PE_W + 1);
    localparam int ROW_W = $clog2(PE_H);

    state_t            state, state_n;
    logic [TILE_W-1:0] tile, n_tiles;
    logic [K_W-1:0]    k;
    logic              empty_job;
    logic              capture, last;
    logic              tile_more;
    logic [ADDR_W-1:0] feed_addr;

    assign feed_addr = ADDR_W'(tile) * ADDR_W'(PE_W) + ADDR_W'(k);
    assign tile_more = ({1'b0, tile} + (TILE_W + 1)'(1)) < {1'b0, n_tiles};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_n      = state;
        busy         = 1'b0;
        done         = 1'b0;
        bias_rd_en   = 1'b0;
        bias_rd_addr = '0;
        ifm_rd_en    = 1'b0;
        ifm_rd_addr  = '0;
        wgt_rd_en    = 1'b0;
        wgt_rd_addr  = '0;
        pe_en        = 1'b0;
        pe_ifmap     = '0;
        pe_weight    = '0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = (num_tiles == '0) ? DONE : BIAS;
            end
            BIAS: begin
                busy = 1'b1;
                if (!pe_valid) begin
                    bias_rd_en   = 1'b1;
                    bias_rd_addr = ADDR_W'(tile);
                    state_n      = FEED;
                end
            end
            FEED: begin
                busy = 1'b1;
                if (k < K_W'(PE_W)) begin
                    ifm_rd_en   = 1'b1;
                    ifm_rd_addr = feed_addr;
                    wgt_rd_en   = 1'b1;
                    wgt_rd_addr = feed_addr;
                end
                if (k != '0) begin
                    pe_ifmap  = ifm_rd_data;
                    pe_weight = wgt_rd_data;
                end
                pe_en = (k == K_W'(1));
                if (k == K_W'(PE_W)) state_n = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (pe_valid) begin
                    capture = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (last) state_n = tile_more ? BIAS : DONE;
            end
            DONE: begin
                // An empty job spends one extra busy cycle here so done lands two cycles after start.
                if (empty_job) begin
                    busy = 1'b1;
                end else begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Job/tile/operand counters and the bias holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile      <= '0;
            n_tiles   <= '0;
            k         <= '0;
            empty_job <= 1'b0;
            pe_bias   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_tiles   <= num_tiles;
                        tile      <= '0;
                        empty_job <= (num_tiles == '0);
                    end
                end
                BIAS: k <= '0;
                FEED: begin
                    if (k == '0) pe_bias <= bias_rd_data;
                    k <= k + K_W'(1);
                end
                DRAIN: begin
                    if (last && tile_more) tile <= tile + TILE_W'(1);
                end
                DONE: empty_job <= 1'b0;
                default: ;
            endcase
        end
    end

    pe_ofmap_serializer #(
        .PE_H  (PE_H),
        .ACC_W (ACC_W),
        .ROW_W (ROW_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .ofmap     (pe_ofmap),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .last      (last)
    );

    assign out_tile = out_valid ? tile : '0;

endmodule

// File: tb/tb_pe_block_sched.sv
// Scoreboard bench for pe_block_sched with behavioural buffers and a PE_block model.
module tb_pe_block_sched;
    import pe_pkg::*;

    localparam int ADDR_W = 10;
    localparam int TILE_W = 8;
    localparam int ROW_W  = $clog2(PE_H);
    localparam int LAT    = PE_W + 2;
    localparam int BUDGET = 2000;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      start = 1'b0;
    logic [TILE_W-1:0]         num_tiles = '0;
    logic                      busy, done;
    logic                      ifm_rd_en, wgt_rd_en, bias_rd_en;
    logic [ADDR_W-1:0]         ifm_rd_addr, wgt_rd_addr, bias_rd_addr;
    logic [DATA_SIZE-1:0]      ifm_rd_data = '0;
    logic [PE_H*DATA_SIZE-1:0] wgt_rd_data = '0;
    logic [PE_H*ACC_W-1:0]     bias_rd_data = '0;
    logic                      pe_en;
    logic [DATA_SIZE-1:0]      pe_ifmap;
    logic [PE_H*DATA_SIZE-1:0] pe_weight;
    logic [PE_H*ACC_W-1:0]     pe_bias;
    logic                      pe_valid = 1'b0;
    logic [PE_H*ACC_W-1:0]     pe_ofmap = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic [ACC_W-1:0]          out_data;
    logic [ROW_W-1:0]          out_row;
    logic [TILE_W-1:0]         out_tile;

    pe_block_sched #(
        .DATA_SIZE (DATA_SIZE),
        .PE_W      (PE_W),
        .PE_H      (PE_H),
        .ACC_W     (ACC_W),
        .ADDR_W    (ADDR_W),
        .TILE_W    (TILE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_tiles    (num_tiles),
        .busy         (busy),
        .done         (done),
        .ifm_rd_en    (ifm_rd_en),
        .ifm_rd_addr  (ifm_rd_addr),
        .ifm_rd_data  (ifm_rd_data),
        .wgt_rd_en    (wgt_rd_en),
        .wgt_rd_addr  (wgt_rd_addr),
        .wgt_rd_data  (wgt_rd_data),
        .bias_rd_en   (bias_rd_en),
        .bias_rd_addr (bias_rd_addr),
        .bias_rd_data (bias_rd_data),
        .pe_en        (pe_en),
        .pe_ifmap     (pe_ifmap),
        .pe_weight    (pe_weight),
        .pe_bias      (pe_bias),
        .pe_valid     (pe_valid),
        .pe_ofmap     (pe_ofmap),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_tile     (out_tile)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TILE_W-1:0] tile;
        logic [ROW_W-1:0]  row;
        logic [ACC_W-1:0]  data;
    } exp_t;

    exp_t sbq[$];
    int   ifm_log[$], wgt_log[$], bias_log[$];
    int   n_tests = 0, n_fail = 0;
    int   pe_en_cnt = 0, done_cnt = 0;
    bit   chk_pv = 1'b0;
    bit   ready_mode = 1'b0;
    int   hold_extra = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Golden buffer contents, indexed by address.
    function automatic logic [DATA_SIZE-1:0] ifm_f(input int a);
        return DATA_SIZE'(a * 7 + 3);
    endfunction

    function automatic logic [PE_H*DATA_SIZE-1:0] wgt_f(input int a);
        logic [PE_H*DATA_SIZE-1:0] w;
        for (int r = 0; r < PE_H; r++) w[r*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(a * 3 + r * 11 + 1);
        return w;
    endfunction

    function automatic logic [PE_H*ACC_W-1:0] bias_f(input int t);
        logic [PE_H*ACC_W-1:0] b;
        for (int r = 0; r < PE_H; r++) b[r*ACC_W +: ACC_W] = ACC_W'(t * 1000 + r * 17 + 5);
        return b;
    endfunction

    function automatic logic [ACC_W-1:0] gold(input int t, input int r);
        logic [PE_H*ACC_W-1:0]     b;
        logic [PE_H*DATA_SIZE-1:0] w;
        logic [ACC_W-1:0]          s;
        b = bias_f(t);
        s = b[r*ACC_W +: ACC_W];
        for (int k = 0; k < PE_W; k++) begin
            w = wgt_f(t * PE_W + k);
            s = s + ACC_W'(ifm_f(t * PE_W + k)) * ACC_W'(w[r*DATA_SIZE +: DATA_SIZE]);
        end
        return s;
    endfunction

    // Buffers: request seen in cycle c, data presented from mid-cycle c+1.
    bit ifm_req = 0, wgt_req = 0, bias_req = 0;
    int ifm_a = 0, wgt_a = 0, bias_a = 0;
    always @(negedge clk) begin
        if (ifm_req)  ifm_rd_data  = ifm_f(ifm_a);
        if (wgt_req)  wgt_rd_data  = wgt_f(wgt_a);
        if (bias_req) bias_rd_data = bias_f(bias_a);
        #2;
        ifm_req  = !rst && ifm_rd_en;
        wgt_req  = !rst && wgt_rd_en;
        bias_req = !rst && bias_rd_en;
        ifm_a    = int'(ifm_rd_addr);
        wgt_a    = int'(wgt_rd_addr);
        bias_a   = int'(bias_rd_addr);
    end

    // PE_block model: accumulate PE_W operands after pe_en, raise pe_valid LAT cycles later.
    logic [ACC_W-1:0] acc [PE_H];
    bit collecting = 0;
    int kcnt = 0, wait_cnt = 0, pv_left = 0;
    always @(negedge clk) begin
        if (rst) begin
            pe_valid = 1'b0;
            pe_ofmap = '0;
            collecting = 0;
            wait_cnt = 0;
            pv_left = 0;
        end else begin
            if (pv_left > 0) begin
                pv_left--;
                if (pv_left == 0) pe_valid = 1'b0;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    for (int r = 0; r < PE_H; r++) pe_ofmap[r*ACC_W +: ACC_W] = acc[r];
                    pe_valid = 1'b1;
                    pv_left = 1 + hold_extra;
                end
            end
        end
        #2;
        if (!rst) begin
            if (pe_en) begin
                collecting = 1;
                kcnt = 0;
                wait_cnt = LAT;
                for (int r = 0; r < PE_H; r++) acc[r] = pe_bias[r*ACC_W +: ACC_W];
            end
            if (collecting) begin
                for (int r = 0; r < PE_H; r++)
                    acc[r] = acc[r] + ACC_W'(pe_ifmap) * ACC_W'(pe_weight[r*DATA_SIZE +: DATA_SIZE]);
                kcnt++;
                if (kcnt == PE_W) collecting = 0;
            end
        end
    end

    // out_ready: steady high, or the 1-0-0-1 pattern.
    logic [3:0] rpat = 4'b1001;
    int ridx = 0;
    always @(negedge clk) begin
        if (ready_mode) begin
            out_ready = rpat[ridx];
            ridx = (ridx + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor and scoreboard compare, sampled well after all drivers settle.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (pe_en) pe_en_cnt++;
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
            end
            if (ifm_rd_en)  ifm_log.push_back(int'(ifm_rd_addr));
            if (wgt_rd_en)  wgt_log.push_back(int'(wgt_rd_addr));
            if (bias_rd_en) bias_log.push_back(int'(bias_rd_addr));
            if (bias_rd_en && chk_pv) check("bias_vs_pe_valid", pe_valid, 0);
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("out_unexpected", out_valid, 0);
                end else begin
                    check("out_tile", out_tile, sbq[0].tile);
                    check("out_row",  out_row,  sbq[0].row);
                    check("out_data", out_data, sbq[0].data);
                    if (out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic push_job(input int n);
        for (int t = 0; t < n; t++)
            for (int r = 0; r < PE_H; r++)
                sbq.push_back('{tile: TILE_W'(t), row: ROW_W'(r), data: gold(t, r)});
        ifm_log.delete();
        wgt_log.delete();
        bias_log.delete();
    endtask

    task automatic run_job(input int n, input int poke_at);
        int d0, p0, cyc;
        push_job(n);
        d0 = done_cnt;
        p0 = pe_en_cnt;
        @(negedge clk); start = 1'b1; num_tiles = TILE_W'(n);
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke_at) begin
                check("busy_before_poke", busy, 1);
                start = 1'b1;
                num_tiles = TILE_W'(5);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("pe_en_count", pe_en_cnt - p0, n);
        check("sb_drained", sbq.size(), 0);
        check("idle_after", busy, 0);
        sbq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, cyc;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pe_en", pe_en, 0);
        check("rst_reads", {ifm_rd_en, wgt_rd_en, bias_rd_en}, 0);
        check("rst_pe_bias", pe_bias, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single tile, golden results.
        run_job(1, -1);

        // Three tiles: address ordering.
        run_job(3, -1);
        check("ifm_addr_count", ifm_log.size(), 3 * PE_W);
        check("wgt_addr_count", wgt_log.size(), 3 * PE_W);
        for (int i = 0; i < ifm_log.size(); i++) check("ifm_addr", ifm_log[i], i);
        for (int i = 0; i < wgt_log.size(); i++) check("wgt_addr", wgt_log[i], i);
        check("bias_addr_count", bias_log.size(), 3);
        for (int i = 0; i < bias_log.size(); i++) check("bias_addr", bias_log[i], i);

        // Back-pressure during drain.
        ready_mode = 1'b1;
        run_job(2, -1);
        ready_mode = 1'b0;

        // pe_valid held into the next tile's BIAS.
        hold_extra = 12;
        chk_pv = 1'b1;
        run_job(2, -1);
        check("hold_bias_reads", bias_log.size(), 2);
        chk_pv = 1'b0;
        hold_extra = 0;
        repeat (4) @(negedge clk);

        // Empty job: one busy cycle, done two cycles after start.
        push_job(0);
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; num_tiles = '0;
        @(negedge clk); start = 1'b0;
        #1;
        check("empty_busy_s1", busy, 1);
        check("empty_done_s1", done, 0);
        @(negedge clk); #1;
        check("empty_done_s2", done, 1);
        check("empty_busy_s2", busy, 0);
        @(negedge clk); #1;
        check("empty_done_s3", done, 0);
        repeat (2) @(negedge clk);
        check("empty_reads", ifm_log.size() + wgt_log.size() + bias_log.size(), 0);
        check("empty_done_cnt", done_cnt - d0, 1);

        // Start while busy is ignored.
        run_job(1, 5);

        // Reset during FEED of tile 1, then replay tile 0.
        push_job(3);
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; num_tiles = TILE_W'(3);
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (bias_log.size() < 2 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_bias1_seen", bias_log.size(), 2);
        check("abort_in_feed", ifm_rd_en, 1);
        check("abort_tile0_drained", sbq.size(), 2 * PE_H);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_reads", {ifm_rd_en, wgt_rd_en, bias_rd_en}, 0);
        check("abort_pe_en", pe_en, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_pe_bias", pe_bias, 0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run_job(1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
